// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared types for the iterative shifter (shift modes, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================

package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter, shifts by k (0..STEP) in one
//               of LSL/LSR/ASR/ROR with an externally supplied sign bit.
// Revision    : 1.0 - initial release
// ============================================================================

module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] data,
    input  shift_mode_e      mode,
    input  logic [KW-1:0]    k,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    localparam int XW  = WIDTH + STEP;
    localparam int XIW = $clog2(XW);

    logic [STEP-1:0]  w_fill;
    logic [XW-1:0]    w_ext;
    logic [WIDTH-1:0] w_rsh;
    logic [XIW-1:0]   w_idx;

    // Right shifts select a WIDTH window out of {fill, data}; k never exceeds STEP.
    always_comb begin
        w_fill = '0;
        case (mode)
            SH_ASR:  w_fill = {STEP{sign}};
            SH_ROR:  w_fill = data[STEP-1:0];
            default: w_fill = '0;
        endcase
        w_ext = {w_fill, data};
        w_rsh = '0;
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_idx    = XIW'(i) + XIW'(k);
            w_rsh[i] = w_ext[w_idx];
        end
        result = (mode == SH_LSL) ? (data << k) : w_rsh;
    end

endmodule

`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iter_shifter
// Description : Multi-cycle LSL/LSR/ASR/ROR shifter, at most STEP positions per
//               clock, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================

module iter_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int          KW     = $clog2(STEP + 1);
    localparam logic [AW:0] c_step = (AW + 1)'(STEP);

    state_e           r_state;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_rem;
    shift_mode_e      r_mode;
    logic             r_sign;
    logic             r_busy;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic [AW:0]      w_rem_ext;
    logic [AW:0]      w_rem_next;
    logic [KW-1:0]    w_k;
    logic [WIDTH-1:0] w_step_data;

    // Step size is the remaining amount, capped at STEP.
    always_comb begin
        w_rem_ext  = {1'b0, r_rem};
        w_k        = (w_rem_ext > c_step) ? KW'(STEP) : w_rem_ext[KW-1:0];
        w_rem_next = w_rem_ext - (AW + 1)'(w_k);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data   (r_data),
        .mode   (r_mode),
        .k      (w_k),
        .sign   (r_sign),
        .result (w_step_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_rem       <= '0;
            r_mode      <= SH_LSL;
            r_sign      <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data <= in_data;
                        r_rem  <= in_amt;
                        r_mode <= shift_mode_e'(in_mode);
                        r_sign <= in_data[WIDTH-1];
                        r_busy <= 1'b1;
                        if (in_amt == '0) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_data;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_data <= w_step_data;
                    r_rem  <= w_rem_next[AW-1:0];
                    if (w_rem_next == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_step_data;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // in_ready must fall with rst itself, not one edge later.
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_shifter
// Description : Self-checking bench for iter_shifter (WIDTH=32, STEP=4).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_iter_shifter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // Reference model state: one request in flight at most.
    logic        m_busy  = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_exp   = '0;
    logic [31:0] m_last  = '0;
    int          m_vcyc  = 0;

    iter_shifter #(
        .WIDTH (32),
        .STEP  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input int m);
        case (m)
            0:       return d << a;
            1:       return d >> a;
            2:       return $signed(d) >>> a;
            default: return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: result appears ceil(amt/4) edges after the accept edge, leaves on out_ready.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= '0;
        end else if (m_busy) begin
            if (m_valid && out_ready) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end else if (!m_valid && (cyc + 1 == m_vcyc)) begin
                m_valid <= 1'b1;
                m_last  <= m_exp;
            end
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_exp  <= ref_shift(in_data, int'(in_amt), int'(in_mode));
            m_vcyc <= cyc + 1 + (int'(in_amt) + 3) / 4;
            if (in_amt == 5'd0) begin
                m_valid <= 1'b1;
                m_last  <= in_data;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !rst});
            chk("out_data", out_data, m_last);
        end
    end

    task automatic run_req(input logic [31:0] d, input int a, input int m,
                           input logic [31:0] exp, input int exp_lat, input int hold);
        int  acc;
        bit  got;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = 5'(a);
        in_mode   = 2'(m);
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        acc      = cyc;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_amt   = 5'($urandom_range(0, 31));
        got      = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(cyc - acc + 1), 32'(exp_lat));
            chk("result", out_data, exp);
        end
        for (int h = 0; h < hold; h++) begin
            in_valid = h[0];
            in_data  = $urandom;
            in_amt   = 5'($urandom_range(0, 31));
            @(negedge clk);
            chk("hold_data", out_data, exp);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        #2 rst = 1'b0;
        #1 chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        run_req(32'h8000_0010, 3, 2, 32'hF000_0002, 2, 0);
        run_req(32'h0000_0001, 31, 0, 32'h8000_0000, 9, 0);
        run_req(32'hFFFF_FFFF, 8, 1, 32'h00FF_FFFF, 3, 0);
        run_req(32'h0000_00F1, 4, 3, 32'h1000_000F, 2, 0);
        run_req(32'h7000_0000, 5, 2, 32'h0380_0000, 3, 0);
        for (int m = 0; m < 4; m++) run_req(32'hDEAD_BEEF, 0, m, 32'hDEAD_BEEF, 1, 0);
        run_req(32'h8000_0010, 3, 2, 32'hF000_0002, 2, 5);

        // Abort an amt-31 shift two cycles in.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        in_amt   = 5'd31;
        in_mode  = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        run_req(32'hFFFF_0000, 16, 2, 32'hFFFF_FFFF, 5, 0);

        // Random traffic; the per-cycle model check covers results and latency.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_amt    = 5'($urandom_range(0, 31));
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
